data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 124 ++++++++++++
 tb/tb_data_cache.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word CPU port
// and a 128-bit block interface to data memory.
module data_cache #(
    parameter int LINES = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [127:0]       data_q [LINES];
    logic [127:0]       data_d [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [1:0]         offset;
    logic               hit;
    logic               request;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^ADDRESS[1:0];

    always_comb begin
        idx      = ADDRESS[4 +: IDX_W];
        addr_tag = ADDRESS[31 -: TAG_W];
        offset   = ADDRESS[3:2];
        hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
        request  = READ || WRITE;
        READDATA = data_q[idx][{offset, 5'b0} +: 32];
    end

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        data_d        = data_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        if (WRITE) begin
                            data_d[idx][{offset, 5'b0} +: 32] = WRITEDATA;
                            dirty_d[idx] = 1'b1;
                        end
                    end else begin
                        BUSYWAIT = 1'b1;
                        state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = data_q[idx];
                if (!MEM_BUSYWAIT) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
                if (!MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                // The held request is re-evaluated as a hit once back in IDLE.
                BUSYWAIT     = 1'b1;
                data_d[idx]  = MEM_READDATA;
                tag_d[idx]   = addr_tag;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and data survive reset; only suppress updates during it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: CPU-visible memory image model plus a latency-programmable
// block memory, and directed scenarios with hand-computed expectations.
module tb_data_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         READ = 1'b0;
    logic         WRITE = 1'b0;
    logic [31:0]  ADDRESS = '0;
    logic [31:0]  WRITEDATA = '0;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int cnt = 0;
    bit started = 1'b0;

    logic [127:0] mem_blk [logic [27:0]];
    logic [31:0]  shadow  [logic [29:0]];

    data_cache #(.LINES(8)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Untouched memory words hold their own byte address.
    function automatic logic [127:0] mem_block(input logic [27:0] a);
        logic [127:0] b;
        if (mem_blk.exists(a)) return mem_blk[a];
        for (int unsigned w = 0; w < 4; w++) b[w*32 +: 32] = {a, 2'(w), 2'b00};
        return b;
    endfunction

    function automatic logic [31:0] shadow_word(input logic [29:0] wa);
        logic [127:0] b;
        if (shadow.exists(wa)) return shadow[wa];
        b = mem_block(wa[29:2]);
        return b[{wa[1:0], 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] shadow_block(input logic [27:0] a);
        logic [127:0] b;
        for (int unsigned w = 0; w < 4; w++) b[w*32 +: 32] = shadow_word({a, 2'(w)});
        return b;
    endfunction

    // Block memory: busy for 'lat' cycles, completes in cycle lat+1.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt != lat);

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (cnt == lat) begin
                cnt <= 0;
                if (MEM_WRITE) mem_blk[MEM_ADDRESS] = MEM_WRITEDATA;
                else MEM_READDATA <= mem_block(MEM_ADDRESS);
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // CPU-visible image: accepted stores; dirty data is lost on reset.
    always @(posedge CLK) begin
        if (RESET) shadow.delete();
        else if (WRITE && BUSYWAIT === 1'b0) shadow[ADDRESS[31:2]] = WRITEDATA;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("mem_excl", 128'(MEM_READ && MEM_WRITE), 128'(0));
            if (!RESET && READ && !WRITE && BUSYWAIT === 1'b0)
                chk("rd_model", 128'(READDATA), 128'(shadow_word(ADDRESS[31:2])));
            if (MEM_WRITE)
                chk("wb_model", MEM_WRITEDATA, shadow_block(MEM_ADDRESS));
            if (!READ && !WRITE) begin
                chk("idle_busy", 128'(BUSYWAIT), 128'(0));
                chk("idle_mrd", 128'(MEM_READ), 128'(0));
                chk("idle_mwr", 128'(MEM_WRITE), 128'(0));
            end
        end
    end

    int pre, post, nwb, nal;
    logic [27:0]  wba, ala;
    logic [127:0] wbd, blk;
    logic [31:0]  rdat;

    task automatic run_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        bit done;
        pre = 0; post = 0; nwb = 0; nal = 0;
        wba = '0; ala = '0; wbd = '0; rdat = '0; done = 1'b0;
        @(posedge CLK); #1;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (BUSYWAIT === 1'b0) begin
                done = 1'b1;
                rdat = READDATA;
            end else if (MEM_WRITE) begin
                if (nwb == 0) begin wba = MEM_ADDRESS; wbd = MEM_WRITEDATA; end
                nwb++;
            end else if (MEM_READ) begin
                if (nal == 0) ala = MEM_ADDRESS;
                nal++;
            end else if (nwb == 0 && nal == 0) begin
                pre++;
            end else begin
                post++;
            end
        end
        if (!done) chk("req_timeout", 128'(done), 128'(1));
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        started = 1'b1;
        @(negedge CLK);
        chk("rst_busy", 128'(BUSYWAIT), 128'(0));
        chk("rst_mrd", 128'(MEM_READ), 128'(0));

        // Cold read miss, clean line
        lat = 2;
        run_req(1, 0, 32'h44, 32'h0);
        chk("cold_pre", 128'(pre), 128'(1));
        chk("cold_wb", 128'(nwb), 128'(0));
        chk("cold_nal", 128'(nal), 128'(3));
        chk("cold_ala", 128'(ala), 128'(28'h4));
        chk("cold_upd", 128'(post), 128'(1));
        chk("cold_rd", 128'(rdat), 128'(32'h44));

        // Write hit, then reads in the same line
        run_req(0, 1, 32'h48, 32'hDEADBEEF);
        chk("whit_stall", 128'(pre + post + nwb + nal), 128'(0));
        run_req(1, 0, 32'h48, 32'h0);
        chk("whit_stall2", 128'(pre + post + nwb + nal), 128'(0));
        chk("whit_rd", 128'(rdat), 128'(32'hDEADBEEF));
        run_req(1, 0, 32'h4C, 32'h0);
        chk("whit_rd_nb", 128'(rdat), 128'(32'h4C));

        // Dirty eviction with long memory latency
        lat = 5;
        run_req(1, 0, 32'hC8, 32'h0);
        chk("evict_pre", 128'(pre), 128'(1));
        chk("evict_nwb", 128'(nwb), 128'(6));
        chk("evict_wba", 128'(wba), 128'(28'h4));
        chk("evict_wbd", wbd, {32'h4C, 32'hDEADBEEF, 32'h44, 32'h40});
        chk("evict_nal", 128'(nal), 128'(6));
        chk("evict_ala", 128'(ala), 128'(28'hC));
        chk("evict_upd", 128'(post), 128'(1));
        chk("evict_rd", 128'(rdat), 128'(32'hC8));
        blk = mem_block(28'h4);
        chk("evict_mem", 128'(blk[95:64]), 128'(32'hDEADBEEF));

        // Reset in the middle of ALLOCATE
        @(posedge CLK); #1;
        READ = 1'b1; ADDRESS = 32'h1C4;
        for (int i = 0; i < 20 && !MEM_READ; i++) @(negedge CLK);
        chk("rst_alloc_seen", 128'(MEM_READ), 128'(1));
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 READ = 1'b0;
        @(negedge CLK);
        chk("rst_alloc_mrd", 128'(MEM_READ), 128'(0));
        chk("rst_alloc_busy", 128'(BUSYWAIT), 128'(0));
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_busy", 128'(BUSYWAIT), 128'(0));
        chk("post_rst_mrd", 128'(MEM_READ), 128'(0));
        lat = 1;
        run_req(1, 0, 32'h1C4, 32'h0);
        chk("rerd_nwb", 128'(nwb), 128'(0));
        chk("rerd_nal", 128'(nal), 128'(2));
        chk("rerd_rd", 128'(rdat), 128'(32'h1C4));

        // Write miss on a clean (invalid) line, zero-latency memory
        lat = 0;
        run_req(0, 1, 32'h100, 32'h12345678);
        chk("wmiss_pre", 128'(pre), 128'(1));
        chk("wmiss_nwb", 128'(nwb), 128'(0));
        chk("wmiss_nal", 128'(nal), 128'(1));
        chk("wmiss_ala", 128'(ala), 128'(28'h10));
        chk("wmiss_upd", 128'(post), 128'(1));
        run_req(1, 0, 32'h100, 32'h0);
        chk("wmiss_stall", 128'(pre + post + nwb + nal), 128'(0));
        chk("wmiss_rd", 128'(rdat), 128'(32'h12345678));

        // Evict the merged line, then READ+WRITE together acts as a store
        run_req(1, 0, 32'h180, 32'h0);
        chk("ev0_nwb", 128'(nwb), 128'(1));
        chk("ev0_wba", 128'(wba), 128'(28'h10));
        chk("ev0_wbd", wbd, {32'h10C, 32'h108, 32'h104, 32'h12345678});
        chk("ev0_ala", 128'(ala), 128'(28'h18));
        chk("ev0_rd", 128'(rdat), 128'(32'h180));
        run_req(1, 1, 32'h184, 32'hCAFEF00D);
        chk("rw_stall", 128'(pre + post + nwb + nal), 128'(0));
        run_req(1, 0, 32'h184, 32'h0);
        chk("rw_rd", 128'(rdat), 128'(32'hCAFEF00D));

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

endmodule
